// File: rtl/timer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : timer_pkg
// Description : Shared state encoding and prescaler width helper for the timer.
// Revision    : 1.0  initial release
// ============================================================================
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int unsigned prescale_width(input int unsigned p);
        int unsigned w;
        w = $clog2(p);
        return (w < 1) ? 1 : w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rate_divider.sv
`default_nettype none
// ============================================================================
// Module      : rate_divider
// Description : PRESCALE-cycle down-counter producing a one-cycle tick while enabled.
// Revision    : 1.0  initial release
// ============================================================================
module rate_divider
    import timer_pkg::*;
#(
    parameter int unsigned PRESCALE = 1
) (
    input  logic i_clk,
    input  logic i_clr,
    input  logic i_en,
    input  logic i_reload,
    output logic o_tick
);

    localparam int unsigned     c_PW  = prescale_width(PRESCALE);
    localparam logic [c_PW-1:0] c_TOP = c_PW'(PRESCALE - 1);

    logic [c_PW-1:0] r_cnt;

    // Tick is combinational from the registered count so the FSM acts on it the same cycle
    assign o_tick = i_en && (r_cnt == '0);

    always_ff @(posedge i_clk or posedge i_clr) begin
        if (i_clr) begin
            r_cnt <= '0;
        end else if (i_reload || o_tick) begin
            r_cnt <= c_TOP;
        end else if (i_en) begin
            r_cnt <= r_cnt - c_PW'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/countdown_timer.sv
`default_nettype none
// ============================================================================
// Module      : countdown_timer
// Description : Loadable, pausable down-counter with terminal-count strobe and auto-reload.
// Revision    : 1.0  initial release
// ============================================================================
module countdown_timer
    import timer_pkg::*;
#(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned PRESCALE = 1
) (
    input  logic             i_clk,
    input  logic             i_clr,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_d,
    input  logic             i_en,
    input  logic             i_auto_reload,
    output logic [WIDTH-1:0] o_q,
    output logic             o_tc,
    output logic             o_busy
);

    state_t           r_state;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_reload;
    logic             r_tc;

    state_t           w_state_nxt;
    logic [WIDTH-1:0] w_q_nxt;
    logic [WIDTH-1:0] w_reload_nxt;
    logic             w_tc_nxt;
    logic             w_div_en;
    logic             w_tick;

    assign w_div_en = i_en && (r_state == RUN);

    rate_divider #(
        .PRESCALE (PRESCALE)
    ) u_rate_divider (
        .i_clk    (i_clk),
        .i_clr    (i_clr),
        .i_en     (w_div_en),
        .i_reload (i_load),
        .o_tick   (w_tick)
    );

    always_ff @(posedge i_clk or posedge i_clr) begin
        if (i_clr) begin
            r_state  <= IDLE;
            r_q      <= '0;
            r_reload <= '0;
            r_tc     <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_q      <= w_q_nxt;
            r_reload <= w_reload_nxt;
            r_tc     <= w_tc_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_q_nxt      = r_q;
        w_reload_nxt = r_reload;
        w_tc_nxt     = 1'b0;
        // Load outranks a coincident terminal tick, suppressing its strobe
        if (i_load) begin
            w_q_nxt      = i_d;
            w_reload_nxt = i_d;
            w_state_nxt  = (i_d != '0) ? RUN : IDLE;
        end else if (r_state == RUN && w_tick) begin
            if (r_q > WIDTH'(1)) begin
                w_q_nxt = r_q - WIDTH'(1);
            end else if (r_q == WIDTH'(1)) begin
                w_tc_nxt = 1'b1;
                if (i_auto_reload) begin
                    w_q_nxt = r_reload;
                end else begin
                    w_q_nxt     = '0;
                    w_state_nxt = DONE;
                end
            end
        end
    end

    assign o_q    = r_q;
    assign o_tc   = r_tc;
    assign o_busy = (r_state == RUN);

endmodule
`default_nettype wire

// File: tb/tb_countdown_timer.sv
`default_nettype none
// ============================================================================
// Module      : tb_countdown_timer
// Description : Scoreboard bench driving PRESCALE=1 and PRESCALE=4 timers in parallel.
// Revision    : 1.0  initial release
// ============================================================================
module tb_countdown_timer;

    localparam int unsigned c_WIDTH = 4;

    typedef struct {
        int q;
        int tc;
        int busy;
    } exp_t;

    logic               clk;
    logic               rst;
    logic               i_load;
    logic [c_WIDTH-1:0] i_d;
    logic               i_en;
    logic               i_auto_reload;
    logic [c_WIDTH-1:0] o_q1, o_q4;
    logic               o_tc1, o_tc4;
    logic               o_busy1, o_busy4;

    int n_checks = 0;
    int n_errors = 0;

    exp_t sb1[$];
    exp_t sb4[$];

    // Reference model state, index 0 -> PRESCALE 1, index 1 -> PRESCALE 4
    int m_q[2], m_rl[2], m_pre[2], m_tc[2], m_run[2], m_done[2];
    int c_PS[2] = '{1, 4};

    countdown_timer #(.WIDTH(c_WIDTH), .PRESCALE(1)) u_dut1 (
        .i_clk(clk), .i_clr(rst), .i_load(i_load), .i_d(i_d), .i_en(i_en),
        .i_auto_reload(i_auto_reload), .o_q(o_q1), .o_tc(o_tc1), .o_busy(o_busy1)
    );

    countdown_timer #(.WIDTH(c_WIDTH), .PRESCALE(4)) u_dut4 (
        .i_clk(clk), .i_clr(rst), .i_load(i_load), .i_d(i_d), .i_en(i_en),
        .i_auto_reload(i_auto_reload), .o_q(o_q4), .o_tc(o_tc4), .o_busy(o_busy4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_q[k] = 0; m_rl[k] = 0; m_pre[k] = 0;
            m_tc[k] = 0; m_run[k] = 0; m_done[k] = 0;
        end
    endtask

    task automatic model_step(input int ld, input int d, input int en, input int ar);
        for (int k = 0; k < 2; k++) begin
            m_tc[k] = 0;
            if (ld != 0) begin
                m_q[k] = d; m_rl[k] = d; m_pre[k] = c_PS[k] - 1;
                m_run[k] = (d != 0); m_done[k] = 0;
            end else if (m_run[k] != 0 && en != 0) begin
                if (m_pre[k] > 0) begin
                    m_pre[k]--;
                end else begin
                    m_pre[k] = c_PS[k] - 1;
                    if (m_q[k] >= 2) m_q[k]--;
                    else begin
                        m_tc[k] = 1;
                        if (ar != 0) m_q[k] = m_rl[k];
                        else begin
                            m_q[k] = 0; m_run[k] = 0; m_done[k] = 1;
                        end
                    end
                end
            end
        end
    endtask

    task automatic step(input int ld, input int d, input int en, input int ar);
        exp_t e1, e4;
        i_load = ld[0]; i_d = d[c_WIDTH-1:0]; i_en = en[0]; i_auto_reload = ar[0];
        model_step(ld, d, en, ar);
        sb1.push_back('{m_q[0], m_tc[0], m_run[0]});
        sb4.push_back('{m_q[1], m_tc[1], m_run[1]});
        @(posedge clk);
        #1;
        e1 = sb1.pop_front();
        e4 = sb4.pop_front();
        check("q_p1",    int'(o_q1),    e1.q);
        check("tc_p1",   int'(o_tc1),   e1.tc);
        check("busy_p1", int'(o_busy1), e1.busy);
        check("q_p4",    int'(o_q4),    e4.q);
        check("tc_p4",   int'(o_tc4),   e4.tc);
        check("busy_p4", int'(o_busy4), e4.busy);
    endtask

    task automatic run(input int n, input int en, input int ar);
        for (int i = 0; i < n; i++) step(0, 0, en, ar);
    endtask

    task automatic clr_pulse();
        #2 rst = 1'b1;
        #1;
        model_reset();
        check("clr_q_p1",    int'(o_q1),    0);
        check("clr_tc_p1",   int'(o_tc1),   0);
        check("clr_busy_p1", int'(o_busy1), 0);
        check("clr_q_p4",    int'(o_q4),    0);
        check("clr_busy_p4", int'(o_busy4), 0);
        #1 rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; i_load = 1'b0; i_d = '0; i_en = 1'b0; i_auto_reload = 1'b0;
        model_reset();
        #12;
        check("rst_q_p1",    int'(o_q1),    0);
        check("rst_tc_p1",   int'(o_tc1),   0);
        check("rst_busy_p1", int'(o_busy1), 0);
        check("rst_q_p4",    int'(o_q4),    0);
        rst = 1'b0;
        run(3, 1, 0);

        // One-shot countdown from 3, then idle in DONE
        step(1, 3, 1, 0); run(14, 1, 0);
        // Auto-reload period of 2
        step(1, 2, 1, 1); run(40, 1, 1);
        // Prescaled countdown from 2
        step(1, 2, 1, 0); run(12, 1, 0);
        // Pause mid-count, then resume
        step(1, 5, 1, 0); run(2, 1, 0); run(3, 0, 0); run(16, 1, 0);
        // Asynchronous clear mid-run
        step(1, 5, 1, 0); run(2, 1, 0); clr_pulse(); run(8, 1, 0);
        // Load coincident with the terminal tick, then load of zero
        step(1, 3, 1, 0); run(2, 1, 0); step(1, 9, 1, 0); run(3, 1, 0);
        step(1, 0, 1, 0); run(5, 1, 1);
        // Maximum load value, no wrap
        step(1, 15, 1, 0); run(64, 1, 0);
        // Randomised mix
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 9) == 0) ? 1 : 0, int'($urandom_range(0, 15)),
                 ($urandom_range(0, 3) != 0) ? 1 : 0, int'($urandom_range(0, 1)));
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
